// File: rtl/sum_stream_arbiter_pkg.sv
// rtl/sum_stream_arbiter_pkg.sv - shared state encoding, width default and stream slice helper
package sum_stream_arbiter_pkg;

  localparam int INT_W_DEF = 8;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_STREAM = 3'd2,
    ST_END    = 3'd3,
    ST_WAIT   = 3'd4,
    ST_RESP   = 3'd5
  } state_t;

  // Low bit of requester idx's slice in a flattened N*w stream bus.
  function automatic int slice_lo(input int idx, input int w);
    return idx * w;
  endfunction

endpackage

// File: rtl/sum_rr_pick.sv
// rtl/sum_rr_pick.sv - rotate-priority encoder: first set req bit at or after ptr, wrapping
module sum_rr_pick
  import sum_stream_arbiter_pkg::*;
#(
  parameter int N   = 4,
  parameter int IDW = 2
) (
  input  logic [N-1:0]   req,
  input  logic [IDW-1:0] ptr,
  output logic [IDW-1:0] id,
  output logic           found
);

  always_comb begin
    int idx;
    idx   = 0;
    id    = '0;
    found = 1'b0;
    for (int k = 0; k < N; k++) begin
      idx = (int'(ptr) + k) % N;
      if (!found && req[idx]) begin
        found = 1'b1;
        id    = IDW'(idx);
      end
    end
  end

endmodule

// File: rtl/sum_stream_arbiter.sv
// rtl/sum_stream_arbiter.sv - shares one stream-sum reducer among N requesters
// Optional: SUM_ARB_PRIO0_EN gives requester 0 absolute priority in IDLE.
module sum_stream_arbiter
  import sum_stream_arbiter_pkg::*;
#(
  parameter int N     = 4,
  parameter int INT_W = INT_W_DEF,
  parameter int IDW   = 2
) (
  input  logic               clk,
  input  logic               nrst,
  input  logic [N-1:0]       rq_valid,
  input  logic [N*INT_W-1:0] rq_s,
  input  logic [N-1:0]       rq_s_valid,
  input  logic [N-1:0]       rq_s_last,
  output logic [N-1:0]       rq_s_ready,
  output logic [N-1:0]       rs_valid,
  output logic [INT_W-1:0]   rs_data,
  input  logic [N-1:0]       rs_ready,
  output logic               red_in_valid,
  output logic [INT_W-1:0]   red_s,
  output logic               red_s_valid,
  output logic               red_s_end,
  input  logic               red_s_ready,
  input  logic               red_out_valid,
  input  logic [INT_W-1:0]   red_out,
  output logic               red_out_ready,
  output logic [IDW-1:0]     grant_id,
  output logic               busy
);

  localparam logic [N-1:0] ONE_HOT0 = {{(N-1){1'b0}}, 1'b1};

  state_t           state;
  logic [IDW-1:0]   rr_ptr;
  logic [INT_W-1:0] result;
  logic [N-1:0]     pick_req;
  logic [IDW-1:0]   pick_id;
  logic             pick_found;
  logic [IDW-1:0]   sel_id;
  logic             sel_found;
  logic             beat_fire;
  logic [IDW-1:0]   next_ptr;

`ifdef SUM_ARB_PRIO0_EN
  assign pick_req  = rq_valid & ~ONE_HOT0;
  assign sel_found = rq_valid[0] | pick_found;
  assign sel_id    = rq_valid[0] ? '0 : pick_id;
`else
  assign pick_req  = rq_valid;
  assign sel_found = pick_found;
  assign sel_id    = pick_id;
`endif

  sum_rr_pick #(.N(N), .IDW(IDW)) u_pick (
    .req   (pick_req),
    .ptr   (rr_ptr),
    .id    (pick_id),
    .found (pick_found)
  );

  // Zero-latency beat path, gated so nothing leaks outside STREAM.
  always_comb begin
    red_s       = '0;
    red_s_valid = 1'b0;
    rq_s_ready  = '0;
    if (state == ST_STREAM) begin
      red_s                = rq_s[slice_lo(int'(grant_id), INT_W) +: INT_W];
      red_s_valid          = rq_s_valid[grant_id];
      rq_s_ready[grant_id] = red_s_ready;
    end
  end

  assign beat_fire = red_s_valid & red_s_ready;
  assign next_ptr  = (grant_id == IDW'(N - 1)) ? '0 : grant_id + 1'b1;
  assign rs_data   = result;

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state         <= ST_IDLE;
      rr_ptr        <= '0;
      grant_id      <= '0;
      busy          <= 1'b0;
      red_in_valid  <= 1'b0;
      red_s_end     <= 1'b0;
      red_out_ready <= 1'b0;
      rs_valid      <= '0;
      result        <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (sel_found) begin
            grant_id     <= sel_id;
            busy         <= 1'b1;
            red_in_valid <= 1'b1;
            state        <= ST_START;
          end
        end
        ST_START: begin
          red_in_valid <= 1'b0;
          state        <= ST_STREAM;
        end
        ST_STREAM: begin
          if (beat_fire && rq_s_last[grant_id]) begin
            red_s_end <= 1'b1;
            state     <= ST_END;
          end
        end
        ST_END: begin
          red_s_end     <= 1'b0;
          red_out_ready <= 1'b1;
          state         <= ST_WAIT;
        end
        ST_WAIT: begin
          if (red_out_valid) begin
            result        <= red_out;
            red_out_ready <= 1'b0;
            rs_valid      <= ONE_HOT0 << grant_id;
            state         <= ST_RESP;
          end
        end
        ST_RESP: begin
          if (rs_ready[grant_id]) begin
            rs_valid <= '0;
            rr_ptr   <= next_ptr;
            busy     <= 1'b0;
            state    <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sum_stream_arbiter.sv
// tb/tb_sum_stream_arbiter.sv - directed self-checking bench for sum_stream_arbiter
module tb_sum_stream_arbiter;

  localparam int N = 4;
  localparam int W = 8;

  logic           clk = 1'b0;
  logic           nrst;
  logic [N-1:0]   rq_valid, rq_s_valid, rq_s_last, rq_s_ready, rs_valid, rs_ready;
  logic [N*W-1:0] rq_s;
  logic [W-1:0]   rs_data, red_s;
  logic           red_in_valid, red_s_valid, red_s_end, red_s_ready, red_out_ready, busy;
  logic           red_out_valid = 1'b0;
  logic [W-1:0]   red_out = '0;
  logic [1:0]     grant_id;

  int checks = 0;
  int errors = 0;

  sum_stream_arbiter #(.N(N), .INT_W(W), .IDW(2)) dut (
    .clk(clk), .nrst(nrst),
    .rq_valid(rq_valid), .rq_s(rq_s), .rq_s_valid(rq_s_valid), .rq_s_last(rq_s_last),
    .rq_s_ready(rq_s_ready), .rs_valid(rs_valid), .rs_data(rs_data), .rs_ready(rs_ready),
    .red_in_valid(red_in_valid), .red_s(red_s), .red_s_valid(red_s_valid),
    .red_s_end(red_s_end), .red_s_ready(red_s_ready), .red_out_valid(red_out_valid),
    .red_out(red_out), .red_out_ready(red_out_ready), .grant_id(grant_id), .busy(busy)
  );

  always #5 clk = ~clk;

  // Behavioural reducer: START clears, beats accumulate, result one cycle after end.
  logic [W-1:0] acc = '0;
  always @(posedge clk) begin
    if (red_in_valid) acc <= '0;
    else if (red_s_valid && red_s_ready) acc <= acc + red_s;
    if (red_out_valid && red_out_ready) red_out_valid <= 1'b0;
    if (red_s_end) begin
      red_out_valid <= 1'b1;
      red_out       <= acc;
    end
  end

  int n_start = 0, n_end = 0, n_beats = 0, stray = 0, mirror = 0;
  always @(posedge clk) begin
    if (red_in_valid) n_start <= n_start + 1;
    if (red_s_end) n_end <= n_end + 1;
    if (red_s_valid && red_s_ready) n_beats <= n_beats + 1;
  end
  always @(negedge clk) begin
    if (nrst) begin
      if ((rq_s_ready & ~(4'b0001 << grant_id)) != 4'b0000) stray <= stray + 1;
      if (red_s_valid && (rq_s_ready[grant_id] !== red_s_ready)) mirror <= mirror + 1;
    end
  end

  logic [30:0] outs;
  assign outs = {red_in_valid, red_s_valid, red_s_end, red_out_ready, busy,
                 red_s, rs_data, rs_valid, rq_s_ready, grant_id};

  logic [W-1:0] beats [8];

  task automatic drive_job(input int id, input int nb, input int stall,
                           output logic [W-1:0] res, output logic [N-1:0] rsv,
                           output logic to, output logic stable, output logic newg);
    int cyc;
    to = 1'b0; stable = 1'b1; newg = 1'b0;
    @(posedge clk); #1;
    rq_valid[id] = 1'b1;
    for (int i = 0; i < nb; i++) begin
      rq_s[id*W +: W] = beats[i];
      rq_s_valid[id]  = 1'b1;
      rq_s_last[id]   = (i == nb - 1);
      cyc = 0;
      do begin @(negedge clk); cyc++; end while (!rq_s_ready[id] && cyc < 100);
      if (!rq_s_ready[id]) to = 1'b1;
      @(posedge clk); #1;
    end
    rq_s_valid[id] = 1'b0;
    rq_s_last[id]  = 1'b0;
    cyc = 0;
    do begin @(negedge clk); cyc++; end while (!rs_valid[id] && cyc < 100);
    if (!rs_valid[id]) to = 1'b1;
    res = rs_data;
    rsv = rs_valid;
    for (int s = 0; s < stall; s++) begin
      @(negedge clk);
      if (rs_data !== res || rs_valid !== rsv) stable = 1'b0;
      if (red_in_valid || !busy || int'(grant_id) != id) newg = 1'b1;
    end
    rs_ready[id] = 1'b1;
    @(posedge clk); #1;
    rs_ready[id] = 1'b0;
    rq_valid[id] = 1'b0;
  endtask

  task automatic test_reset();
    nrst = 1'b0; rq_valid = '0; rq_s = '0; rq_s_valid = '0; rq_s_last = '0;
    rs_ready = '0; red_s_ready = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checks++;
    if (outs !== '0) begin errors++; $display("FAIL reset_hold outs=%h exp=0", outs); end
    @(posedge clk); #1;
    nrst = 1'b1;
    @(negedge clk);
    checks++;
    if (outs !== '0) begin errors++; $display("FAIL reset_release outs=%h exp=0", outs); end
  endtask

  task automatic test_table(input logic [N-1:0] req, input logic reassert,
                            input logic [N-1:0] eg0, input logic [N-1:0] eg1, input logic [N-1:0] eg2,
                            input logic [W-1:0] ed0, input logic [W-1:0] ed1, input logic [W-1:0] ed2);
    logic [N-1:0] eg [3];
    logic [W-1:0] ed [3];
    logic [N-1:0] got;
    int cyc;
    eg[0] = eg0; eg[1] = eg1; eg[2] = eg2;
    ed[0] = ed0; ed[1] = ed1; ed[2] = ed2;
    @(posedge clk); #1;
    rq_s = {8'd4, 8'd3, 8'd2, 8'd1};
    rq_valid = req; rq_s_valid = req; rq_s_last = req;
    for (int j = 0; j < 3; j++) begin
      cyc = 0;
      do begin @(negedge clk); cyc++; end while (rs_valid == '0 && cyc < 200);
      checks++;
      if (rs_valid !== eg[j]) begin errors++; $display("FAIL grant_order[%0d] rs_valid=%b exp=%b", j, rs_valid, eg[j]); end
      checks++;
      if (rs_data !== ed[j]) begin errors++; $display("FAIL job_sum[%0d] rs_data=%h exp=%h", j, rs_data, ed[j]); end
      got = rs_valid;
      rs_ready = got;
      @(posedge clk); #1;
      rs_ready = '0;
      if (!reassert) begin
        rq_valid &= ~got; rq_s_valid &= ~got; rq_s_last &= ~got;
      end
    end
    rq_valid = '0; rq_s_valid = '0; rq_s_last = '0;
    repeat (2) @(negedge clk);
    checks++;
    if (busy !== 1'b0) begin errors++; $display("FAIL idle_after_table busy=%b exp=0", busy); end
  endtask

  task automatic test_contention();
    test_table(4'b1011, 1'b0, 4'b0001, 4'b0010, 4'b1000, 8'd1, 8'd2, 8'd4);
  endtask

  task automatic test_prio_rotation();
`ifdef SUM_ARB_PRIO0_EN
    test_table(4'b0111, 1'b1, 4'b0001, 4'b0001, 4'b0001, 8'd1, 8'd1, 8'd1);
`else
    test_table(4'b0111, 1'b1, 4'b0001, 4'b0010, 4'b0100, 8'd1, 8'd2, 8'd3);
`endif
  endtask

  task automatic test_single_job();
    logic [W-1:0] res; logic [N-1:0] rsv; logic to, st, ng;
    int s0, e0, b0;
    beats[0] = 8'd1; beats[1] = 8'd2; beats[2] = 8'd3; beats[3] = 8'hff;
    s0 = n_start; e0 = n_end; b0 = n_beats;
    drive_job(1, 4, 0, res, rsv, to, st, ng);
    checks++; if (to !== 1'b0) begin errors++; $display("FAIL single_timeout to=%b exp=0", to); end
    checks++; if (rsv !== 4'b0010) begin errors++; $display("FAIL single_rs_valid got=%b exp=0010", rsv); end
    checks++; if (res !== 8'h05) begin errors++; $display("FAIL single_sum got=%h exp=05", res); end
    checks++; if (n_start - s0 != 1) begin errors++; $display("FAIL single_start_pulses got=%0d exp=1", n_start - s0); end
    checks++; if (n_end - e0 != 1) begin errors++; $display("FAIL single_end_pulses got=%0d exp=1", n_end - e0); end
    checks++; if (n_beats - b0 != 4) begin errors++; $display("FAIL single_beats got=%0d exp=4", n_beats - b0); end
    @(negedge clk);
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL single_busy_drop busy=%b exp=0", busy); end
  endtask

  task automatic test_backpressure();
    logic [W-1:0] res; logic [N-1:0] rsv; logic to, st, ng;
    int b0, m0;
    logic bp_on;
    beats[0] = 8'd10; beats[1] = 8'd20; beats[2] = 8'd30;
    b0 = n_beats; m0 = mirror;
    bp_on = 1'b1; red_s_ready = 1'b1;
    fork
      begin drive_job(1, 3, 0, res, rsv, to, st, ng); bp_on = 1'b0; end
      begin
        int k;
        k = 0;
        while (bp_on && k < 300) begin
          @(posedge clk); #1;
          if (bp_on) red_s_ready = ~red_s_ready;
          k++;
        end
      end
    join
    red_s_ready = 1'b1;
    checks++; if (to !== 1'b0) begin errors++; $display("FAIL bp_timeout to=%b exp=0", to); end
    checks++; if (res !== 8'd60) begin errors++; $display("FAIL bp_sum got=%0d exp=60", res); end
    checks++; if (n_beats - b0 != 3) begin errors++; $display("FAIL bp_beats got=%0d exp=3", n_beats - b0); end
    checks++; if (mirror != m0) begin errors++; $display("FAIL bp_ready_mirror mismatches=%0d exp=0", mirror - m0); end
  endtask

  task automatic test_result_stall();
    logic [W-1:0] res; logic [N-1:0] rsv; logic to, st, ng;
    int cyc;
    beats[0] = 8'd7; beats[1] = 8'd9;
    @(posedge clk); #1;
    rq_valid[2] = 1'b1;
    rq_s[7:0] = 8'd4; rq_valid[0] = 1'b1; rq_s_valid[0] = 1'b1; rq_s_last[0] = 1'b1;
    drive_job(2, 2, 5, res, rsv, to, st, ng);
    checks++; if (to !== 1'b0) begin errors++; $display("FAIL stall_timeout to=%b exp=0", to); end
    checks++; if (rsv !== 4'b0100 || res !== 8'd16) begin errors++; $display("FAIL stall_result rs_valid=%b rs_data=%0d exp=0100/16", rsv, res); end
    checks++; if (st !== 1'b1) begin errors++; $display("FAIL stall_stable stable=%b exp=1", st); end
    checks++; if (ng !== 1'b0) begin errors++; $display("FAIL stall_new_grant seen=%b exp=0", ng); end
    cyc = 0;
    do begin @(negedge clk); cyc++; end while (!rs_valid[0] && cyc < 100);
    checks++;
    if (rs_valid !== 4'b0001 || rs_data !== 8'd4) begin errors++; $display("FAIL stall_pending_req rs_valid=%b rs_data=%0d exp=0001/4", rs_valid, rs_data); end
    rs_ready[0] = 1'b1;
    @(posedge clk); #1;
    rs_ready = '0; rq_valid = '0; rq_s_valid = '0; rq_s_last = '0;
  endtask

  task automatic test_reset_mid_stream();
    logic [W-1:0] res; logic [N-1:0] rsv; logic to, st, ng;
    logic [W-1:0] pre [2];
    int cyc;
    pre[0] = 8'd100; pre[1] = 8'd50;
    @(posedge clk); #1;
    rq_valid[1] = 1'b1;
    for (int i = 0; i < 2; i++) begin
      rq_s[W +: W] = pre[i]; rq_s_valid[1] = 1'b1; rq_s_last[1] = 1'b0;
      cyc = 0;
      do begin @(negedge clk); cyc++; end while (!rq_s_ready[1] && cyc < 100);
      @(posedge clk); #1;
    end
    rq_s[W +: W] = 8'd77;
    @(negedge clk); #2;
    nrst = 1'b0;
    #1;
    checks++;
    if (outs !== '0) begin errors++; $display("FAIL midreset_async outs=%h exp=0", outs); end
    @(posedge clk); #1;
    nrst = 1'b1;
    rq_valid = '0; rq_s_valid = '0; rq_s_last = '0;
    beats[0] = 8'd5; beats[1] = 8'd5;
    drive_job(1, 2, 0, res, rsv, to, st, ng);
    checks++; if (to !== 1'b0) begin errors++; $display("FAIL midreset_timeout to=%b exp=0", to); end
    checks++; if (res !== 8'd10) begin errors++; $display("FAIL midreset_resubmit got=%0d exp=10", res); end
  endtask

  task automatic test_ready_isolation();
    checks++;
    if (stray != 0) begin errors++; $display("FAIL non_granted_ready cycles=%0d exp=0", stray); end
  endtask

  initial begin
    test_reset();
    test_contention();
    test_prio_rotation();
    test_single_job();
    test_backpressure();
    test_result_stall();
    test_reset_mid_stream();
    test_ready_isolation();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
